pkt_buf_rd_arbiter: RTL and testbench



---
 rtl/pkt_buf_rd_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_pkt_buf_rd_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_buf_rd_arbiter.sv
// Packet-buffer read arbiter: round-robin grants whole packets from two
// requesters onto one eSRAM read port and routes returned flits back to the
// owning requester using a tag FIFO that tracks outstanding reads.
module pkt_buf_rd_arbiter #(
    parameter int PKTBUF_AWIDTH = 16,
    parameter int LEN_WIDTH     = 6,
    parameter int MAX_INFLIGHT  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [PKTBUF_AWIDTH-1:0] req0_addr,
    input  logic [LEN_WIDTH-1:0]     req0_len,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [PKTBUF_AWIDTH-1:0] req1_addr,
    input  logic [LEN_WIDTH-1:0]     req1_len,
    output logic                     req1_ready,
    output logic                     out0_valid,
    output logic                     out0_sop,
    output logic                     out0_eop,
    output logic [519:0]             out0_data,
    input  logic                     out0_almost_full,
    output logic                     out1_valid,
    output logic                     out1_sop,
    output logic                     out1_eop,
    output logic [519:0]             out1_data,
    input  logic                     out1_almost_full,
    output logic                     esram_pkt_buf_rden,
    output logic [PKTBUF_AWIDTH-1:0] esram_pkt_buf_rdaddress,
    input  logic                     esram_pkt_buf_rd_valid,
    input  logic [519:0]             esram_pkt_buf_rddata,
    output logic                     busy,
    output logic                     err_unexpected
);

    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t                   state_q, state_d;
    logic                     last_grant_q, last_grant_d;
    logic                     port_q, port_d;
    logic                     first_q, first_d;
    logic [PKTBUF_AWIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]     remaining_q, remaining_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            inflight_q, inflight_d;
    logic                     err_q, err_d;
    logic                     o0_valid_q, o0_valid_d, o0_sop_q, o0_sop_d, o0_eop_q, o0_eop_d;
    logic                     o1_valid_q, o1_valid_d, o1_sop_q, o1_sop_d, o1_eop_q, o1_eop_d;
    logic [519:0]             o0_data_q, o0_data_d, o1_data_q, o1_data_d;
    logic [2:0]               tag_mem [MAX_INFLIGHT];
    logic [2:0]               tag_in, tag_out;
    logic                     grant0, grant1, stall, push, pop;

    // Arbitration and flit issue: grant in IDLE, one flit per unstalled ISSUE cycle
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        first_d      = first_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        push         = 1'b0;
        // Ready is gated by rst so no acceptance pulse leaks out while held in reset
        grant0 = ~rst & req0_valid & (~req1_valid | last_grant_q);
        grant1 = ~rst & req1_valid & (~req0_valid | ~last_grant_q);
        stall  = (port_q ? out1_almost_full : out0_almost_full) | (inflight_q == MAX_CNT);
        tag_in = {port_q, first_q, remaining_q == LEN_WIDTH'(1)};
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    req0_ready   = 1'b1;
                    port_d       = 1'b0;
                    last_grant_d = 1'b0;
                    cur_addr_d   = req0_addr;
                    remaining_d  = (req0_len == '0) ? LEN_WIDTH'(1) : req0_len;
                    first_d      = 1'b1;
                    state_d      = ISSUE;
                end else if (grant1) begin
                    req1_ready   = 1'b1;
                    port_d       = 1'b1;
                    last_grant_d = 1'b1;
                    cur_addr_d   = req1_addr;
                    remaining_d  = (req1_len == '0) ? LEN_WIDTH'(1) : req1_len;
                    first_d      = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    push        = 1'b1;
                    cur_addr_d  = cur_addr_q + PKTBUF_AWIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    first_d     = 1'b0;
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag FIFO bookkeeping and routing of returned flits to the tagged port
    always_comb begin
        pop        = esram_pkt_buf_rd_valid & (inflight_q != '0);
        tag_out    = tag_mem[rd_ptr_q];
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        inflight_d = inflight_q;
        if (push && !pop) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!push && pop) begin
            inflight_d = inflight_q - CW'(1);
        end
        err_d      = err_q | (esram_pkt_buf_rd_valid & (inflight_q == '0));
        o0_valid_d = pop & ~tag_out[2];
        o1_valid_d = pop & tag_out[2];
        o0_sop_d   = tag_out[1];
        o0_eop_d   = tag_out[0];
        o1_sop_d   = tag_out[1];
        o1_eop_d   = tag_out[0];
        o0_data_d  = o0_valid_d ? esram_pkt_buf_rddata : o0_data_q;
        o1_data_d  = o1_valid_d ? esram_pkt_buf_rddata : o1_data_q;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            first_q      <= 1'b0;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inflight_q   <= '0;
            err_q        <= 1'b0;
            o0_valid_q   <= 1'b0;
            o0_sop_q     <= 1'b0;
            o0_eop_q     <= 1'b0;
            o0_data_q    <= '0;
            o1_valid_q   <= 1'b0;
            o1_sop_q     <= 1'b0;
            o1_eop_q     <= 1'b0;
            o1_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            first_q      <= first_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            err_q        <= err_d;
            o0_valid_q   <= o0_valid_d;
            o0_sop_q     <= o0_sop_d;
            o0_eop_q     <= o0_eop_d;
            o0_data_q    <= o0_data_d;
            o1_valid_q   <= o1_valid_d;
            o1_sop_q     <= o1_sop_d;
            o1_eop_q     <= o1_eop_d;
            o1_data_q    <= o1_data_d;
        end
    end

    // Tag storage; flushed by resetting the pointers rather than the contents
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= tag_in;
        end
    end

    assign esram_pkt_buf_rden      = push;
    assign esram_pkt_buf_rdaddress = cur_addr_q;
    assign busy                    = (state_q != IDLE) | (inflight_q != '0);
    assign err_unexpected          = err_q;
    assign out0_valid              = o0_valid_q;
    assign out0_sop                = o0_sop_q & o0_valid_q;
    assign out0_eop                = o0_eop_q & o0_valid_q;
    assign out0_data               = o0_data_q;
    assign out1_valid              = o1_valid_q;
    assign out1_sop                = o1_sop_q & o1_valid_q;
    assign out1_eop                = o1_eop_q & o1_valid_q;
    assign out1_data               = o1_data_q;

endmodule

// File: tb/tb_pkt_buf_rd_arbiter.sv
// Scoreboard bench for pkt_buf_rd_arbiter with a variable-latency eSRAM model.
module tb_pkt_buf_rd_arbiter;

    localparam int AW = 16;
    localparam int LW = 6;
    localparam int MI = 8;
    localparam int DW = 520;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [LW-1:0] req0_len, req1_len;
    logic          out0_valid, out0_sop, out0_eop, out0_almost_full;
    logic          out1_valid, out1_sop, out1_eop, out1_almost_full;
    logic [DW-1:0] out0_data, out1_data;
    logic          rden, rd_valid, busy, err;
    logic [AW-1:0] rdaddress;
    logic [DW-1:0] rddata;

    always #5 clk = ~clk;

    pkt_buf_rd_arbiter #(.PKTBUF_AWIDTH(AW), .LEN_WIDTH(LW), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
        .out0_valid(out0_valid), .out0_sop(out0_sop), .out0_eop(out0_eop), .out0_data(out0_data),
        .out0_almost_full(out0_almost_full),
        .out1_valid(out1_valid), .out1_sop(out1_sop), .out1_eop(out1_eop), .out1_data(out1_data),
        .out1_almost_full(out1_almost_full),
        .esram_pkt_buf_rden(rden), .esram_pkt_buf_rdaddress(rdaddress),
        .esram_pkt_buf_rd_valid(rd_valid), .esram_pkt_buf_rddata(rddata),
        .busy(busy), .err_unexpected(err)
    );

    typedef struct packed {logic sop; logic eop; logic [DW-1:0] data;} flit_t;
    typedef struct {int due; logic [AW-1:0] addr;} rd_t;
    typedef struct {logic [AW-1:0] addr; logic first;} iss_t;

    flit_t q0[$], q1[$];
    iss_t  addr_q[$];
    rd_t   mem_q[$];
    int    grants[$];
    int    checks = 0, failures = 0;
    int    cyc = 0, lat = 2, outstanding = 0, peak = 0, stray = 0, last_ready_cyc = 0;
    logic  prev_rdv = 1'b0, prev_tag = 1'b0;

    function automatic logic [DW-1:0] flit_data(input logic [AW-1:0] a);
        return {~a, {488{1'b0}}, a};
    endfunction

    task automatic check(input string tag, input logic [DW+1:0] got, input logic [DW+1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void push_pkt(input int p, input logic [AW-1:0] a, input logic [LW-1:0] len);
        int    n;
        flit_t f;
        n = (len == '0) ? 1 : int'(len);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] fa;
            fa     = a + AW'(i);
            f.sop  = (i == 0);
            f.eop  = (i == n - 1);
            f.data = flit_data(fa);
            addr_q.push_back('{fa, i == 0});
            if (p == 0) q0.push_back(f);
            else        q1.push_back(f);
        end
    endfunction

    // Monitor, scoreboard and eSRAM model, all evaluated at the falling edge
    initial begin
        flit_t f;
        rd_t   r;
        iss_t  e;
        rd_valid = 1'b0;
        rddata   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q0.delete(); q1.delete(); addr_q.delete(); mem_q.delete();
                outstanding = 0; prev_rdv = 1'b0; prev_tag = 1'b0; rd_valid = 1'b0;
                continue;
            end
            if (out0_valid || out1_valid || prev_rdv) begin
                check("out_valid", out0_valid | out1_valid, prev_rdv & prev_tag);
                check("out_onehot", out0_valid & out1_valid, 0);
                if (out0_valid) begin
                    if (q0.size() == 0) check("out0_extra", out0_valid, 0);
                    else begin f = q0.pop_front(); check("out0_flit", {out0_sop, out0_eop, out0_data}, f); end
                end
                if (out1_valid) begin
                    if (q1.size() == 0) check("out1_extra", out1_valid, 0);
                    else begin f = q1.pop_front(); check("out1_flit", {out1_sop, out1_eop, out1_data}, f); end
                end
            end
            prev_rdv = 1'b0; prev_tag = 1'b0; rd_valid = 1'b0;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                r = mem_q.pop_front();
                rd_valid = 1'b1; rddata = flit_data(r.addr);
                prev_rdv = 1'b1; prev_tag = (outstanding > 0);
                if (outstanding > 0) outstanding--;
            end else if (stray > 0) begin
                stray--;
                rd_valid = 1'b1; rddata = '1;
                prev_rdv = 1'b1; prev_tag = (outstanding > 0);
                if (outstanding > 0) outstanding--;
            end
            if (req0_ready) begin
                check("ready0_valid", req0_valid, 1);
                grants.push_back(0); last_ready_cyc = cyc; push_pkt(0, req0_addr, req0_len);
            end
            if (req1_ready) begin
                check("ready1_valid", req1_valid, 1);
                grants.push_back(1); last_ready_cyc = cyc; push_pkt(1, req1_addr, req1_len);
            end
            if (rden) begin
                if (addr_q.size() == 0) check("rden_extra", rden, 0);
                else begin
                    e = addr_q.pop_front();
                    check("rdaddr", rdaddress, e.addr);
                    if (e.first) check("rden_lat", cyc, last_ready_cyc + 1);
                end
                mem_q.push_back('{cyc + lat, rdaddress});
                outstanding++;
                if (outstanding > peak) peak = outstanding;
            end
        end
    end

    task automatic run_req(input int p, input int n, input logic [AW-1:0] base, input int len);
        logic got;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (p == 0) begin req0_valid = 1'b1; req0_addr = base + AW'(k * 16); req0_len = LW'(len); end
            else        begin req1_valid = 1'b1; req1_addr = base + AW'(k * 16); req1_len = LW'(len); end
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                got = (p == 0) ? req0_ready : req1_ready;
            end
            if (!got) check("req_timeout", got, 1);
        end
        @(posedge clk); #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && mem_q.size() == 0) break;
        end
        @(negedge clk); #1;
        check("idle_reached", busy, 0);
        check("sb_empty", q0.size() + q1.size() + addr_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 16'h1234; req0_len = 6'd2;
        req1_valid = 1'b0; req1_addr = '0; req1_len = '0;
        out0_almost_full = 1'b0; out1_almost_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", {req0_ready, req1_ready, rden, rdaddress, out0_valid, out1_valid,
                           out0_sop, out0_eop, out1_sop, out1_eop, busy, err}, 0);
        check("rst_data", {out0_data[7:0], out1_data[7:0]}, 0);
        req0_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // single packet, address sequence and sop/eop
        run_req(0, 1, 16'h0010, 3);
        wait_idle();

        // round robin from reset with both requesters holding valid
        pulse_reset();
        grants.delete();
        fork
            run_req(0, 2, 16'h0100, 2);
            run_req(1, 2, 16'h0200, 3);
        join
        wait_idle();
        check("grant_cnt", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) check("grant_order", grants[i], i % 2);

        // address wrap and zero-length packet
        run_req(0, 1, 16'hFFFF, 2);
        wait_idle();
        run_req(1, 1, 16'h0040, 0);
        wait_idle();

        // backpressure from consumer 1 mid-packet
        run_req(1, 1, 16'h0300, 8);
        @(posedge clk); #1 out1_almost_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_rden", rden, 0);
            @(posedge clk); #1;
        end
        out1_almost_full = 1'b0;
        wait_idle();

        // long latency: tag FIFO fills and throttles issue
        lat = 10; peak = 0;
        run_req(0, 1, 16'h0400, 16);
        wait_idle();
        check("inflight_peak", peak, MI);

        // reset mid-packet followed by stray returns
        lat = 4;
        run_req(0, 1, 16'h0500, 8);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_outs", {rden, out0_valid, out1_valid, busy, err, req0_ready, req1_ready}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("err_clear", err, 0);
        stray = 2;
        repeat (6) @(posedge clk);
        #1;
        check("err_sticky", err, 1);
        check("busy_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
